// File: rtl/deadlock_report_arbiter.sv
// Collects per-process deadlock suspects, tracks the lowest-index origin,
// confirms persistent deadlocks and clears tokens on false alarms.
module deadlock_report_arbiter #(
    parameter int PROC_NUM       = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic                rearm,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic [7:0]          origin_idx,
    output logic                token_clear,
    output logic                dl_confirmed,
    output logic [CNT_W-1:0]    dl_event_cnt
);

    localparam int TW = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CONFIRM_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CONFIRMED,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PROC_NUM-1:0] origin_d;
    logic [7:0]          idx_d;
    logic                det_d;
    logic                tc_d;
    logic                conf_d;
    logic [CNT_W-1:0]    cnt_d;

    logic [PROC_NUM-1:0] sel_hot;
    logic [7:0]          sel_idx;
    logic                tracked;

    // Downward scan so the lowest set index is the last one written.
    always_comb begin
        sel_hot = '0;
        sel_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_in_vec[i]) begin
                sel_hot    = '0;
                sel_hot[i] = 1'b1;
                sel_idx    = 8'(i);
            end
        end
    end

    assign tracked = |(dl_in_vec & origin);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        origin_d = origin;
        idx_d    = origin_idx;
        det_d    = dl_detect_out;
        tc_d     = 1'b0;
        conf_d   = dl_confirmed;
        cnt_d    = dl_event_cnt;
        unique case (state_q)
            IDLE: begin
                det_d    = 1'b0;
                origin_d = '0;
                idx_d    = '0;
                conf_d   = 1'b0;
                if (|dl_in_vec) begin
                    state_d  = TRACK;
                    origin_d = sel_hot;
                    idx_d    = sel_idx;
                    det_d    = 1'b1;
                    timer_d  = '0;
                end
            end
            TRACK: begin
                if (tracked) begin
                    if (timer_q == T_LAST) begin
                        state_d = CONFIRMED;
                        conf_d  = 1'b1;
                        if (dl_event_cnt != '1)
                            cnt_d = dl_event_cnt + CNT_W'(1);
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    state_d = CLEAR;
                    tc_d    = 1'b1;
                end
            end
            CONFIRMED: begin
                if (rearm) begin
                    state_d = CLEAR;
                    tc_d    = 1'b1;
                    conf_d  = 1'b0;
                end
            end
            CLEAR: begin
                state_d  = IDLE;
                det_d    = 1'b0;
                origin_d = '0;
                idx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            origin        <= '0;
            origin_idx    <= '0;
            dl_detect_out <= 1'b0;
            token_clear   <= 1'b0;
            dl_confirmed  <= 1'b0;
            dl_event_cnt  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            origin        <= origin_d;
            origin_idx    <= idx_d;
            dl_detect_out <= det_d;
            token_clear   <= tc_d;
            dl_confirmed  <= conf_d;
            dl_event_cnt  <= cnt_d;
        end
    end

endmodule
